// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter
// Round-robin sharing of one synchronous image ROM between two pixel
// requesters. Grants are combinational from the requests and the priority
// pointer. A {valid, id} shift pipeline follows each read through the ROM,
// so returned pixels are steered back to the requester that issued them.

module image_rom_arbiter #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 12,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_rgb
);

  // One stage per cycle from the transfer edge until rom_rgb is valid.
  localparam int DEPTH = ROM_LATENCY + 1;

  logic                  gnt0_next;
  logic                  gnt1_next;
  logic                  transfer;
  logic                  winner_id;
  logic [ADDR_WIDTH-1:0] winner_addr;

  // Index of the most recent winner; the other requester wins a tie.
  logic                  last_reg;
  logic [ADDR_WIDTH-1:0] rom_address_reg;

  logic                  pipe_valid_reg [DEPTH];
  logic                  pipe_id_reg    [DEPTH];

  logic [DATA_WIDTH-1:0] rdata_reg  [2];
  logic                  rvalid_reg [2];

  logic                  tail_valid;
  logic                  tail_id;

  // Round-robin grant: single requester always wins, a tie goes to the
  // requester that is not last; nothing is granted during reset.
  always_comb begin
    gnt0_next = 1'b0;
    gnt1_next = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || last_reg)) begin
        gnt0_next = 1'b1;
      end else if (req1) begin
        gnt1_next = 1'b1;
      end
    end
  end

  assign transfer    = gnt0_next | gnt1_next;
  assign winner_id   = gnt1_next;
  assign winner_addr = gnt1_next ? addr1 : addr0;

  // Priority pointer and ROM address only move on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg        <= 1'b1;
      rom_address_reg <= '0;
    end else if (transfer) begin
      last_reg        <= winner_id;
      rom_address_reg <= winner_addr;
    end
  end

  // Owner-tracking shift pipeline; stage 0 captures the current transfer and
  // the tail lines up with the cycle in which rom_rgb carries that read.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // Head stage: record whether a read was issued and by whom.
        always_ff @(posedge clk) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_id_reg[gi]    <= 1'b0;
          end else begin
            pipe_valid_reg[gi] <= transfer;
            pipe_id_reg[gi]    <= winner_id;
          end
        end
      end else begin : g_body
        // Body stage: plain shift, every cycle.
        always_ff @(posedge clk) begin
          if (rst) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_id_reg[gi]    <= 1'b0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_id_reg[gi]    <= pipe_id_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign tail_valid = pipe_valid_reg[DEPTH-1];
  assign tail_id    = pipe_id_reg[DEPTH-1];

  // Return path: capture rom_rgb for the owning requester and strobe its
  // rvalid for one cycle; data holds between strobes.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= tail_valid && (tail_id == 1'(gi));
          if (tail_valid && (tail_id == 1'(gi))) begin
            rdata_reg[gi] <= rom_rgb;
          end
        end
      end
    end
  endgenerate

  assign gnt0        = gnt0_next;
  assign gnt1        = gnt1_next;
  assign rom_address = rom_address_reg;
  assign rdata0      = rdata_reg[0];
  assign rdata1      = rdata_reg[1];
  assign rvalid0     = rvalid_reg[0];
  assign rvalid1     = rvalid_reg[1];

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Testbench for image_rom_arbiter: a default-latency instance checked by a
// cycle-accurate scoreboard, plus a ROM_LATENCY=3 instance for latency.

module tb_image_rom_arbiter;

  localparam int AW = 20;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: ROM_LATENCY = 1
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_rgb;

  // Instance B: ROM_LATENCY = 3
  logic          req0_b, req1_b;
  logic [AW-1:0] addr0_b, addr1_b;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
  logic [DW-1:0] rdata0_b, rdata1_b;
  logic [AW-1:0] rom_address_b;
  logic [DW-1:0] rom_rgb_b;
  logic [DW-1:0] rom_pipe_b [3];

  image_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .rom_address(rom_address), .rom_rgb(rom_rgb)
  );

  image_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rdata0(rdata0_b), .rvalid0(rvalid0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rdata1(rdata1_b), .rvalid1(rvalid1_b),
    .rom_address(rom_address_b), .rom_rgb(rom_rgb_b)
  );

  // ROM models: rgb = address[11:0], delayed by the instance's latency
  always @(posedge clk) rom_rgb <= rom_address[DW-1:0];
  always @(posedge clk) begin
    rom_pipe_b[0] <= rom_address_b[DW-1:0];
    rom_pipe_b[1] <= rom_pipe_b[0];
    rom_pipe_b[2] <= rom_pipe_b[1];
  end
  assign rom_rgb_b = rom_pipe_b[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard for instance A
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t    sb_q[$];
  logic    armed = 1'b0;
  logic    m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    logic exp_g0, exp_g1;
    logic [AW-1:0] w_addr;
    if (armed) begin
      if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check_val("sb_rvalid", {30'd0, rvalid1, rvalid0}, e.id ? 32'd2 : 32'd1);
        check_val("sb_rdata", e.id ? {20'd0, rdata1} : {20'd0, rdata0}, {20'd0, e.data});
        $display("return id=%0d data=0x%03h cycle=%0d", e.id, e.data, cyc);
      end else begin
        check_val("sb_rvalid_idle", {30'd0, rvalid1, rvalid0}, 32'd0);
      end
      check_val("sb_rom_address", {12'd0, rom_address}, {12'd0, m_addr});
      exp_g0 = !rst && req0 && (!req1 || m_last);
      exp_g1 = !rst && req1 && (!req0 || !m_last);
      check_val("sb_gnt", {30'd0, gnt1, gnt0}, {30'd0, exp_g1, exp_g0});
      if (rst) begin
        sb_q.delete();
        m_last = 1'b1;
        m_addr = '0;
      end else if (exp_g0 || exp_g1) begin
        w_addr = exp_g1 ? addr1 : addr0;
        e.id   = exp_g1;
        e.data = w_addr[DW-1:0];
        e.due  = cyc + 3;
        sb_q.push_back(e);
        m_last = exp_g1;
        m_addr = w_addr;
        $display("transfer id=%0d addr=0x%05h cycle=%0d", e.id, w_addr, cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = '0; addr1 = 20'h200;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = '0; addr1_b = '0;

    // Reset: outputs cleared and no grant while rst is high
    next_cycle();
    armed = 1'b1;
    @(negedge clk);
    check_val("rst_rom_address", {12'd0, rom_address}, 32'd0);
    check_val("rst_rdata", {8'd0, rdata1, rdata0}, 32'd0);
    check_val("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check_val("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // First cycle after reset with both requesting: requester 0 wins
    @(negedge clk);
    check_val("first_contention", {30'd0, gnt1, gnt0}, 32'd1);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;

    // Latency parameter on instance B: single transfer of 0x3FF by req1
    req1_b = 1'b1; addr1_b = 20'h003FF;
    @(negedge clk);
    t = cyc;
    check_val("b_gnt1", {31'd0, gnt1_b}, 32'd1);
    next_cycle();
    req1_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_val("b_rvalid1", {31'd0, rvalid1_b}, (cyc - t == 5) ? 32'd1 : 32'd0);
      check_val("b_rvalid0", {31'd0, rvalid0_b}, 32'd0);
      if (cyc - t == 5) begin
        check_val("b_rdata1", {20'd0, rdata1_b}, 32'h3FF);
        $display("latency3 return data=0x%03h at T+%0d", rdata1_b, cyc - t);
      end
      next_cycle();
    end

    // Single requester streaming 0..9
    for (int i = 0; i < 10; i++) begin
      req0 = 1'b1; addr0 = AW'(i);
      @(negedge clk);
      check_val("stream_gnt0", {31'd0, gnt0}, 32'd1);
      next_cycle();
    end
    req0 = 1'b0;
    repeat (5) next_cycle();

    // Reset mid-flight: transfer 0x055, then reset for one cycle
    req0 = 1'b1; addr0 = 20'h00055;
    @(negedge clk);
    t = cyc;
    check_val("midflight_gnt0", {31'd0, gnt0}, 32'd1);
    next_cycle();
    req0 = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      check_val("midflight_rvalid0", {31'd0, rvalid0}, 32'd0);
      if (i == 2) check_val("midflight_rom_address", {12'd0, rom_address}, 32'd0);
      next_cycle();
    end

    // Contention fairness: 8 cycles, grants must alternate starting with 0
    req0 = 1'b1; req1 = 1'b1; addr0 = 20'h00100; addr1 = 20'h00200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("fair_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) next_cycle();

    // Withdrawal: req1 raised while requester 0 wins, dropped before grant
    req0 = 1'b1; addr0 = 20'h00010; req1 = 1'b1; addr1 = 20'h003A5;
    @(negedge clk);
    check_val("wd_gnt1", {31'd0, gnt1}, 32'd0);
    next_cycle();
    req1 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      req0 = (i < 3);
      addr0 = 20'h00010 + AW'(i);
      @(negedge clk);
      check_val("wd_no_addr1", {31'd0, rom_address == 20'h003A5}, 32'd0);
      check_val("wd_rvalid1", {31'd0, rvalid1}, 32'd0);
      next_cycle();
    end
    req0 = 1'b0;

    // Idle hold after a transfer to 0x0AB
    req0 = 1'b1; addr0 = 20'h000AB;
    @(negedge clk);
    next_cycle();
    req0 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check_val("idle_rom_address", {12'd0, rom_address}, 32'h0AB);
      check_val("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      if (i > 3) check_val("idle_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      next_cycle();
    end

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/image_rom_arbiter.md
# image_rom_arbiter

Round-robin arbiter that shares the single synchronous `image_rom` between two pixel requesters, for example `draw_menu` and a sprite/game renderer. It sits between the draw stages and the ROM on the `clk40MHz` domain. It accepts address requests through a req/gnt handshake, drives the ROM address, tracks which requester owns each in-flight read, and routes returned pixel data back with a per-requester valid strobe. Sustained throughput is one read per cycle.

## Interface
- `ADDR_WIDTH`, default 20: ROM address width.
- `DATA_WIDTH`, default 12: pixel width, 4:4:4 RGB.
- `ROM_LATENCY`, default 1: cycles from the address being presented at the ROM to `rom_rgb` being valid; legal range is 1–4.
- `clk` (in, 1): single clock, `clk40MHz` in the top level.
- `rst` (in, 1): synchronous, active-high reset.
- `req0` (in, 1): requester 0 read request.
- `addr0` (in, ADDR_WIDTH): requester 0 address; must be stable while `req0` is high and `gnt0` is low.
- `gnt0` (out, 1): requester 0 grant; a transfer occurs in any cycle where `req0` and `gnt0` are both high.
- `rdata0` (out, DATA_WIDTH): returned pixel for requester 0.
- `rvalid0` (out, 1): one-cycle strobe; `rdata0` is valid while it is high.
- `req1`, `addr1`, `gnt1`, `rdata1`, `rvalid1`: same as the requester 0 signals, for requester 1.
- `rom_address` (out, ADDR_WIDTH): registered address to `image_rom.address`.
- `rom_rgb` (in, DATA_WIDTH): from `image_rom.rgb`.

## Operation
- Grant logic is combinational from the `req*` inputs and the priority pointer `last`.
  - At most one `gnt` is high per cycle.
  - No `gnt` is high while `rst` is high.
- Arbitration:
  - Only `req0` high: `gnt0`.
  - Only `req1` high: `gnt1`.
  - Both high: grant the requester that is not `last`.
  - Neither high: no grant.
- `last` updates to the granted index only on a transfer. Its reset value is 1, so requester 0 wins the first contention.
- A single active requester is granted every cycle (back-to-back). Under continuous contention, grants alternate 0,1,0,1.
- On a transfer, `rom_address` is loaded with the winner's address at the clock edge. With no transfer, `rom_address` holds its value and no read is tracked.
- Owner tracking uses a shift pipeline of {valid, id} with depth ROM_LATENCY+1, advanced every cycle.
  - Stage 0 is loaded with {transfer, winner id}.
  - The pipeline tail aligns with `rom_rgb` being valid.
- Return path:
  - When the tail is valid, register `rom_rgb` into `rdata[id]` and pulse `rvalid[id]` for one cycle.
  - The other requester's `rvalid` stays 0.
  - `rdata*` holds its value when `rvalid*` is low.
- Requesters must accept data unconditionally; there is no backpressure on the return path.
- A requester may drop `req` before being granted; this is a withdrawal and no read occurs.

## Timing
- Transfer in cycle T:
  - `rom_address` valid in T+1.
  - `rom_rgb` valid in T+1+ROM_LATENCY.
  - `rvalid`/`rdata` valid in T+2+ROM_LATENCY, which is T+3 at the default.
- Latency is fixed and identical for both requesters. Returns are delivered in transfer order.
- Reset values:
  - `rom_address` = 0
  - `rdata0` = `rdata1` = 0
  - `rvalid0` = `rvalid1` = 0
  - all pipeline valid bits = 0
  - `last` = 1
- Reset mid-operation discards in-flight reads. No `rvalid` is asserted for reads transferred before the reset edge.
- With both requests high in the first cycle after reset, `gnt0` = 1.
- Simultaneous transfer and return in the same cycle is normal pipelined operation; both proceed.

## Test plan
- **Single requester streaming.** After reset, hold `req0`=1 with `addr0` = 0,1,2,…,9 advanced on each grant, ROM model rgb = addr[11:0]. Required: `gnt0` high for 10 consecutive cycles; `rvalid0` high for 10 consecutive cycles starting 3 cycles after the first transfer, with `rdata0` = 0x000…0x009 in order; `rvalid1` = 0 throughout.
- **Contention fairness.** Hold `req0` and `req1` high for 8 cycles, `addr0` = 0x100, `addr1` = 0x200. Required: grant order 0,1,0,1,0,1,0,1; `rvalid0` returns 0x100 and `rvalid1` returns 0x200 on alternating cycles, 4 each.
- **Address stability and withdrawal.** Hold `req1` high while requester 0 streams, then drop `req1` before it is granted. Required: no `rom_address` = `addr1` ever appears and `rvalid1` is never asserted.
- **Reset mid-flight.** Make a transfer at T with `addr0` = 0x055, assert `rst` at T+1 for 1 cycle. Required: `rvalid0` stays 0 through T+6; `rom_address` = 0 after reset; the next contention grants requester 0.
- **Latency parameter.** Rebuild with ROM_LATENCY=3 and make a single transfer at T with `addr1` = 0x3FF. Required: `rvalid1` = 1 exactly at T+5 with `rdata1` = 0x3FF, and 0 at all other cycles.
- **Idle hold.** Run 20 cycles with no requests after a transfer to 0x0AB. Required: `rom_address` stays 0x0AB, no `rvalid`, and no `gnt`.
